// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared definitions for the boot-time sysid checker and the sysid slave it reads.
package first_nios2_system_sysid_pkg;

    localparam int unsigned SYSID_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_CHECK,
        ST_DONE
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Single source of truth for the image identity, also used by the sysid slave.
    localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_ID        = 32'd0;
    localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_TIMESTAMP = 32'd1455298001;

endpackage

// File: rtl/first_nios2_system_sysid_wdog.sv
// Saturating stall counter; expired_c flags that LIMIT stalled cycles have elapsed.
module first_nios2_system_sysid_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Clear wins over enable so every state entry starts from zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_W'(LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_c = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time Avalon-MM master: reads sysid ID and timestamp words and reports pass/fail/timeout.
module first_nios2_system_sysid_checker
    import first_nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_e state_q, state_d;
    logic         addr_d, read_d, busy_d, done_d, pass_d, timeout_d;
    logic [31:0]  id_d, ts_d;
    logic         wd_clear, wd_expired;

    assign wd_clear = (state_d != state_q);

    first_nios2_system_sysid_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clock     (clock),
        .reset     (reset),
        .clear     (wd_clear),
        .enable    (avm_read & avm_waitrequest),
        .expired_c (wd_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state_q     <= state_d;
            avm_address <= addr_d;
            avm_read    <= read_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            timeout     <= timeout_d;
            id_value    <= id_d;
            ts_value    <= ts_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = avm_address;
        read_d    = avm_read;
        busy_d    = busy;
        done_d    = 1'b0;
        pass_d    = pass;
        timeout_d = timeout;
        id_d      = id_value;
        ts_d      = ts_value;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    id_d      = '0;
                    ts_d      = '0;
                    addr_d    = SYSID_ADDR_ID;
                    read_d    = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_RD_ID;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                if (!avm_waitrequest) begin
                    if (state_q == ST_RD_ID) begin
                        id_d    = avm_readdata;
                        addr_d  = SYSID_ADDR_TS;
                        state_d = ST_RD_TS;
                    end else begin
                        ts_d    = avm_readdata;
                        read_d  = 1'b0;
                        state_d = ST_CHECK;
                    end
                end else if (wd_expired) begin
                    // Stalled slave: abandon the read and skip the comparison.
                    read_d    = 1'b0;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_CHECK: begin
                pass_d  = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Self-checking bench: randomized sysid slave stalls/data against a transaction-level model.
module tb_first_nios2_system_sysid_checker;

    localparam int unsigned T_OUT = 4;
    localparam logic [31:0] EID  = 32'd0;
    localparam logic [31:0] ETS  = 32'd1455298001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        busy, done, pass, timeout;
    logic [31:0] id_value, ts_value;

    int n_checks = 0;
    int n_errors = 0;

    int          plan_stall [2];
    logic [31:0] plan_data  [2];

    first_nios2_system_sysid_checker #(
        .TIMEOUT_CYCLES (T_OUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sysid slave: each new read stalls plan_stall[addr] cycles, then returns plan_data[addr].
    initial begin
        bit in_read = 0;
        bit cur_addr = 0;
        int remaining = 0;
        forever begin
            @(posedge clock);
            #1;
            if (avm_read) begin
                if (!in_read || (avm_address != cur_addr)) begin
                    in_read   = 1;
                    cur_addr  = avm_address;
                    remaining = plan_stall[avm_address];
                end
                if (remaining > 0) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                    remaining--;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = plan_data[avm_address];
                end
            end else begin
                in_read         = 0;
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata    = $urandom;
            end
        end
    end

    task automatic run_txn(input int s0, input int s1, input logic [31:0] d0,
                           input logic [31:0] d1, input int repulse);
        logic        e_to, e_pass;
        logic [31:0] e_id, e_ts;
        int          e_done_j, e_reads;
        int          n_done = 0, done_j = -1, reads = 0;
        logic        p_read = 0, p_wait = 0, p_addr = 0;

        // Transaction-level expectation
        if (s0 > int'(T_OUT)) begin
            e_to = 1; e_pass = 0; e_id = '0; e_ts = '0;
            e_done_j = int'(T_OUT) + 2;
            e_reads  = int'(T_OUT) + 1;
        end else if (s1 > int'(T_OUT)) begin
            e_to = 1; e_pass = 0; e_id = d0; e_ts = '0;
            e_done_j = s0 + 3 + int'(T_OUT);
            e_reads  = s0 + 2 + int'(T_OUT);
        end else begin
            e_to = 0; e_id = d0; e_ts = d1;
            e_pass   = (d0 == EID) && (d1 == ETS);
            e_done_j = s0 + s1 + 4;
            e_reads  = s0 + s1 + 2;
        end

        plan_stall[0] = s0; plan_stall[1] = s1;
        plan_data[0]  = d0; plan_data[1]  = d1;

        @(negedge clock);
        start = 1'b1;
        for (int j = 1; j <= e_done_j + 6; j++) begin
            @(negedge clock);
            if (j == 1) begin
                check("start_busy", 32'(busy), 32'd1);
                check("start_read", 32'(avm_read), 32'd1);
                check("start_addr", 32'(avm_address), 32'd0);
                check("start_clr", {timeout, pass, 30'd0} | id_value | ts_value, 32'd0);
            end
            if (p_read && p_wait && avm_read)
                check("stall_addr", 32'(avm_address), 32'(p_addr));
            if (avm_read) reads++;
            if (done) begin
                n_done++;
                if (done_j < 0) begin
                    done_j = j;
                    check("done_pass", 32'(pass), 32'(e_pass));
                    check("done_timeout", 32'(timeout), 32'(e_to));
                    check("done_id", id_value, e_id);
                    check("done_ts", ts_value, e_ts);
                    check("done_busy", 32'(busy), 32'd0);
                end
            end
            p_read = avm_read; p_wait = avm_waitrequest; p_addr = avm_address;
            start = (j == repulse) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check("done_count", 32'(n_done), 32'd1);
        check("done_cycle", 32'(done_j), 32'(e_done_j));
        check("read_cycles", 32'(reads), 32'(e_reads));
        check("end_idle_busy", 32'(busy), 32'd0);
        check("held_pass", 32'(pass), 32'(e_pass));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_read"}, 32'(avm_read), 32'd0);
        check({tag, "_addr"}, 32'(avm_address), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_id"}, id_value, 32'd0);
        check({tag, "_ts"}, ts_value, 32'd0);
    endtask

    initial begin
        int s0, s1, rp, est;
        logic [31:0] d0, d1;

        plan_stall[0] = 0; plan_stall[1] = 0;
        plan_data[0]  = EID; plan_data[1] = ETS;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_values("rst");

        run_txn(0, 0, EID, ETS, 0);
        run_txn(3, 3, EID, ETS, 0);
        run_txn(0, 0, EID, ETS - 32'd1, 0);
        run_txn(0, 1000, 32'h1234_5678, ETS, 0);
        run_txn(1000, 0, EID, ETS, 0);
        run_txn(0, 0, EID, ETS, 2);
        run_txn(0, 0, EID, ETS, 4);

        // Reset during an RD_ID stall, after a run that left non-zero status
        run_txn(0, 0, EID, ETS, 0);
        plan_stall[0] = 1000; plan_stall[1] = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("midrst");
        reset = 1'b0;
        @(negedge clock);
        check_reset_values("postrst");
        run_txn(0, 0, EID, ETS, 0);

        for (int k = 0; k < 40; k++) begin
            s0 = $urandom_range(0, 6);
            s1 = $urandom_range(0, 6);
            d0 = ($urandom_range(0, 3) != 0) ? EID : $urandom;
            d1 = ($urandom_range(0, 3) != 0) ? ETS : $urandom;
            est = s0 + s1 + 4 + int'(T_OUT);
            rp = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, est)) : 0;
            if (s0 > int'(T_OUT)) rp = (rp > int'(T_OUT) + 2) ? 0 : rp;
            else if (s1 > int'(T_OUT)) rp = (rp > s0 + 3 + int'(T_OUT)) ? 0 : rp;
            else rp = (rp > s0 + s1 + 4) ? 0 : rp;
            run_txn(s0, s1, d0, d1, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
